sys_bus_interconnect_reg: RTL
=============================

Name: sys_bus_interconnect_reg

Overview:
- Registered, parametrised system-bus decoder/router. One master request is fanned out to SN slaves, selected by address bits [SW+SL-1:SW].
- Adds features the combinational interconnect lacks:
  - one pipeline stage on request strobes
  - single-outstanding transaction tracking
  - multi-slave broadcast writes, acknowledged only after every targeted slave acks
  - a timeout watchdog
  - decode-error responses
  - status counters
- Sits between the PS-side bus bridge and the peripheral register banks.

Parameters:
SN, 16, number of slaves (1..32; need not be a power of two)
SW, 20, slave address width (offset bits below the slave index)
AW, 32, master address width (must be >= SW+SL, where SL=max(1,$clog2(SN)))
DW, 32, data width
TIMEOUT, 255, cycles to wait for all acks before forcing an error; 0 disables the watchdog
BCAST_SRC, 0, slave index whose write window triggers a broadcast
BCAST_MASK, {SN{1'b0}}, extra slaves that also receive broadcast writes
NOFS, 4, number of broadcast offsets
BCAST_OFS, {NOFS*SW{1'b0}}, packed list of SW-bit offsets that trigger a broadcast
ERR_DATA, 32'hDEAD_BEEF, read data returned on error or timeout

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
m_addr  in  AW  master address
m_wdata  in  DW  master write data
m_wen  in  1  write strobe, single-cycle pulse
m_ren  in  1  read strobe, single-cycle pulse
m_rdata  out  DW  read data, valid with m_ack
m_err  out  1  error, valid with m_ack
m_ack  out  1  response pulse
s_addr  out  AW  registered address, shared by all slaves
s_wdata  out  DW  registered write data, shared by all slaves
s_wen  out  SN  per-slave write strobe
s_ren  out  SN  per-slave read strobe
s_rdata  in  SN*DW  per-slave read data, packed
s_err  in  SN  per-slave error
s_ack  in  SN  per-slave ack
busy_o  out  1  transaction in flight
ovr_o  out  1  sticky: a strobe arrived while busy
to_cnt_o  out  16  saturating count of timeouts
clr_i  in  1  synchronous clear of ovr_o and to_cnt_o

Behaviour:
- Reset (async, rst_i=1): all outputs 0, state IDLE, pending mask 0. Reset mid-transaction abandons the transaction; acks arriving after reset are ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE, strobe at cycle T:
  - latch m_addr/m_wdata into s_addr/s_wdata
  - compute target mask; pending <= target
  - at T+1: assert s_wen/s_ren for the targets for exactly one cycle; go to WAIT
- Target mask:
  - normal access: one-hot of the slave index
  - broadcast: m_wen=1, index==BCAST_SRC and m_addr[SW-1:0] equals any BCAST_OFS entry; target = onehot(BCAST_SRC) | BCAST_MASK
  - reads never broadcast
- Decode error: index >= SN, or m_wen and m_ren both set.
  - no slave strobed; go straight to RESP
  - m_ack=1, m_err=1, m_rdata=ERR_DATA at T+2
- WAIT:
  - each cycle, pending &= ~s_ack; s_err of acked targets is ORed into an err accumulator
  - read: s_rdata of the target is captured on its ack
  - acks from non-pending slaves are ignored
  - an ack is accepted in the same cycle as the slave strobe
  - when pending becomes 0, go to RESP
- RESP: one cycle of m_ack=1 with m_err=accumulated error and m_rdata=captured data (0 for writes); then IDLE.
- Latency: minimum strobe-to-m_ack is 2 cycles (slave acks combinationally at T+1).
- Watchdog:
  - counter cleared on entry to WAIT, increments each WAIT cycle
  - if it reaches TIMEOUT with pending≠0: RESP with m_err=1, m_rdata=ERR_DATA; to_cnt_o increments (saturates at 16'hFFFF)
- ovr_o: set to 1 if m_wen or m_ren is asserted while state≠IDLE. That strobe is dropped (no slave sees it).
- clr_i: clears ovr_o and to_cnt_o; a same-cycle set/increment takes priority.
- busy_o = (state≠IDLE).
- Width rules: SL=max(1,$clog2(SN)). The index is compared against SN before decoding. Offset matching uses the full SW bits.

Test Plan:
- Read slave 3 (m_addr=32'h0030_0010), slave acks at T+1 with rdata=32'h1234_5678 -> s_ren=16'h0008 at T+1; m_ack at T+2 with m_rdata=32'h1234_5678, m_err=0.
- Broadcast config BCAST_SRC=0, BCAST_MASK=16'h0006, BCAST_OFS[0]=20'h00100; write 32'h0000_0100 -> s_wen=16'h0007. Slaves ack at T+1, T+3, T+5 -> single m_ack at T+6, m_err=0.
- Same broadcast with slave 2 never acking, TIMEOUT=8 -> m_ack with m_err=1, m_rdata=32'hDEAD_BEEF; to_cnt_o=1. A late ack from slave 2 produces no second m_ack.
- SN=12, read m_addr=32'h00E0_0000 -> no s_ren bit set; m_ack at T+2 with m_err=1, m_rdata=32'hDEAD_BEEF.
- Issue m_wen at T+1 while busy -> ovr_o=1, no second slave strobe. clr_i pulse -> ovr_o=0.
- Assert rst_i during WAIT -> all outputs 0 immediately; a subsequent slave ack gives no m_ack; a new read completes normally.

Source files
------------

// File: rtl/sys_bus_interconnect_reg.sv
`default_nettype none
// ============================================================================
// Module   : sys_bus_interconnect_reg
// Purpose  : Registered system-bus decoder/router. A single master request is
//            routed to one of SN slaves (or broadcast to several), with one
//            pipeline stage on the slave strobes, single-outstanding tracking,
//            a timeout watchdog, decode-error responses and status counters.
// Ports    : clk_i/rst_i      clock, asynchronous active-high reset
//            m_*              master side (addr, wdata, wen, ren, rdata, err, ack)
//            s_*              slave side (shared addr/wdata, per-slave strobes,
//                             packed rdata, per-slave err/ack)
//            busy_o           transaction in flight
//            ovr_o            sticky: strobe arrived while busy
//            to_cnt_o         saturating timeout count
//            clr_i            synchronous clear of ovr_o and to_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module sys_bus_interconnect_reg #(
    parameter int                 SN         = 16,
    parameter int                 SW         = 20,
    parameter int                 AW         = 32,
    parameter int                 DW         = 32,
    parameter int                 TIMEOUT    = 255,
    parameter int                 BCAST_SRC  = 0,
    parameter logic [SN-1:0]      BCAST_MASK = {SN{1'b0}},
    parameter int                 NOFS       = 4,
    parameter logic [NOFS*SW-1:0] BCAST_OFS  = {NOFS*SW{1'b0}},
    parameter logic [DW-1:0]      ERR_DATA   = DW'(32'hDEAD_BEEF)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    m_addr,
    input  logic [DW-1:0]    m_wdata,
    input  logic             m_wen,
    input  logic             m_ren,
    output logic [DW-1:0]    m_rdata,
    output logic             m_err,
    output logic             m_ack,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_wdata,
    output logic [SN-1:0]    s_wen,
    output logic [SN-1:0]    s_ren,
    input  logic [SN*DW-1:0] s_rdata,
    input  logic [SN-1:0]    s_err,
    input  logic [SN-1:0]    s_ack,
    output logic             busy_o,
    output logic             ovr_o,
    output logic [15:0]      to_cnt_o,
    input  logic             clr_i
);

    localparam int SL = (SN > 1) ? $clog2(SN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SL:0]    c_sn          = (SL+1)'(SN);
    localparam logic [SN-1:0]  c_src_onehot  = SN'(1) << BCAST_SRC;
    localparam logic [TW-1:0]  c_wd_last     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SN-1:0]     r_pend;
    logic [SN-1:0]     w_pend_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [DW-1:0]     r_rdata;
    logic [DW-1:0]     w_rdata_nxt;
    logic              r_is_rd;
    logic [TW-1:0]     r_wd;
    logic              w_timeout;
    logic [AW-1:0]     r_s_addr;
    logic [DW-1:0]     r_s_wdata;
    logic [SN-1:0]     r_s_wen;
    logic [SN-1:0]     r_s_ren;
    logic              r_ovr;
    logic [15:0]       r_to_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [SL-1:0]     w_idx;
    logic              w_idx_ok;
    logic [SN-1:0]     w_onehot;
    logic              w_ofs_hit;
    logic              w_bcast;
    logic [SN-1:0]     w_target;
    logic              w_dec_err;
    logic              w_strobe;
    logic              w_accept;
    logic [SN-1:0]     w_acked;

    assign w_idx    = m_addr[SW+SL-1:SW];
    // Range check before decoding: SN need not be a power of two.
    assign w_idx_ok = ({1'b0, w_idx} < c_sn);

    always_comb begin
        w_onehot  = '0;
        w_ofs_hit = 1'b0;
        for (int i = 0; i < SN; i++) begin
            w_onehot[i] = (w_idx == SL'(i));
        end
        for (int k = 0; k < NOFS; k++) begin
            if (m_addr[SW-1:0] == BCAST_OFS[k*SW +: SW]) begin
                w_ofs_hit = 1'b1;
            end
        end
    end

    assign w_bcast   = m_wen && !m_ren && (w_idx == SL'(BCAST_SRC)) && w_ofs_hit;
    assign w_target  = w_bcast ? (c_src_onehot | BCAST_MASK) : w_onehot;
    assign w_dec_err = !w_idx_ok || (m_wen && m_ren);
    assign w_strobe  = m_wen || m_ren;
    assign w_accept  = (r_state == S_IDLE) && w_strobe;
    assign w_acked   = r_pend & s_ack;

    // ------------------------------------------------------------------
    // FSM next state / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    // A decode error passes through WAIT with nothing pending
                    // so its response lands on the same cycle as a
                    // zero-wait slave response.
                    w_state_nxt = S_WAIT;
                    w_pend_nxt  = w_dec_err ? '0 : w_target;
                    w_err_nxt   = w_dec_err;
                    w_rdata_nxt = w_dec_err ? ERR_DATA : '0;
                end
            end
            S_WAIT: begin
                w_pend_nxt = r_pend & ~s_ack;
                if (|(w_acked & s_err)) begin
                    w_err_nxt = 1'b1;
                end
                if (r_is_rd) begin
                    for (int i = 0; i < SN; i++) begin
                        if (w_acked[i]) begin
                            w_rdata_nxt = s_rdata[i*DW +: DW];
                        end
                    end
                end
                if (w_pend_nxt == '0) begin
                    w_state_nxt = S_RESP;
                end else if ((TIMEOUT != 0) && (r_wd == c_wd_last)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                    w_pend_nxt  = '0;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = ERR_DATA;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_is_rd   <= 1'b0;
            r_wd      <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_wen   <= '0;
            r_s_ren   <= '0;
            r_ovr     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            // Slave strobes are single-cycle: only the accept cycle loads them.
            r_s_wen <= '0;
            r_s_ren <= '0;
            if (w_accept) begin
                r_s_addr  <= m_addr;
                r_s_wdata <= m_wdata;
                r_is_rd   <= m_ren;
                if (!w_dec_err) begin
                    if (m_wen) begin
                        r_s_wen <= w_target;
                    end else begin
                        r_s_ren <= w_target;
                    end
                end
            end
            // Watchdog runs only in WAIT, so it is zero on every WAIT entry.
            r_wd <= (r_state == S_WAIT) ? r_wd + 1'b1 : '0;
            if ((r_state != S_IDLE) && w_strobe) begin
                r_ovr <= 1'b1;
            end else if (clr_i) begin
                r_ovr <= 1'b0;
            end
            if (w_timeout) begin
                if (r_to_cnt != 16'hFFFF) begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
            end else if (clr_i) begin
                r_to_cnt <= '0;
            end
        end
    end

    assign m_ack    = (r_state == S_RESP);
    assign m_err    = (r_state == S_RESP) && r_err;
    assign m_rdata  = (r_state == S_RESP) ? r_rdata : '0;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wen    = r_s_wen;
    assign s_ren    = r_s_ren;
    assign busy_o   = (r_state != S_IDLE);
    assign ovr_o    = r_ovr;
    assign to_cnt_o = r_to_cnt;

endmodule
`default_nettype wire
